// File: rtl/div_pkg.sv
// Shared widths, iteration count and FSM encoding for the non-restoring divider.
package div_pkg;
  localparam int DW   = 8;
  localparam int ITER = 8;
  localparam int PRW  = DW + 1;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/cas.sv
// Controlled add/subtract cell: t=1 inverts b so a carry-in of 1 yields a-b.
module cas (
  input  logic a,
  input  logic b,
  input  logic t,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic bx;
  assign bx   = b ^ t;
  assign s    = a ^ bx ^ cin;
  assign cout = (a & bx) | (a & cin) | (bx & cin);
endmodule

// File: rtl/cas_row.sv
// Ripple row of cas cells: s = t ? a - b : a + b, two's complement, PRW bits.
module cas_row
  import div_pkg::*;
(
  input  logic [PRW-1:0] a,
  input  logic [PRW-1:0] b,
  input  logic           t,
  output logic [PRW-1:0] s
);
  logic [PRW-1:0] c;
  assign c[0] = t;

  for (genvar i = 0; i < PRW-1; i++) begin : g_cell
    cas u_cas (.a(a[i]), .b(b[i]), .t(t), .cin(c[i]), .s(s[i]), .cout(c[i+1]));
  end

  // Sign bit: its carry-out is never used, so only the sum is formed.
  assign s[PRW-1] = a[PRW-1] ^ b[PRW-1] ^ t ^ c[PRW-1];
endmodule

// File: rtl/div_nr_8bit.sv
// 8-bit unsigned non-restoring divider: 8 CALC cycles, 1 FIX, 1 DONE; done at accept+10.
module div_nr_8bit
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero
);
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [PRW-1:0] pr;
  logic [DW-1:0]  q;
  logic [DW-1:0]  dvd;
  logic [DW-1:0]  dvs;

  logic [PRW-1:0] row_a;
  logic [PRW-1:0] row_b;
  logic [PRW-1:0] row_s;
  logic           row_t;

  // CALC: shifted {PR,Q} then subtract if old PR >= 0; FIX: restore a negative PR.
  always_comb begin
    row_a = {pr[DW-1:0], q[DW-1]};
    row_t = ~pr[PRW-1];
    if (state == FIX) begin
      row_a = pr;
      row_t = 1'b0;
    end
  end

  assign row_b = {1'b0, dvs};

  cas_row u_row (.a(row_a), .b(row_b), .t(row_t), .s(row_s));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      q           <= '0;
      dvd         <= '0;
      dvs         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dvd   <= dividend;
          dvs   <= divisor;
          q     <= dividend;
          pr    <= '0;
          cnt   <= CW'(ITER-1);
          busy  <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          pr  <= row_s;
          q   <= {q[DW-2:0], ~row_s[PRW-1]};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (pr[PRW-1]) pr <= row_s;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          done        <= 1'b1;
          div_by_zero <= (dvs == '0);
          quotient    <= (dvs == '0) ? {DW{1'b1}} : q;
          remainder   <= (dvs == '0) ? dvd : pr[DW-1:0];
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_nr_8bit.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, random sweep vs arithmetic model.
module tb_div_nr_8bit;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  always #5 clk = ~clk;

  div_nr_8bit dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [7:0] a, b, q, r;
    logic       z;
  } vec_t;

  vec_t tbl[10];
  int checks = 0;
  int errors = 0;

  logic [7:0] gq, gr;
  logic       gz;
  int         glat, gbusy_err, pulses;
  int         ea, eb, eq, er, ez;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drives one start, returns results sampled #1 after the edge that raised done.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r, output logic z,
                        output int lat, output int busy_err);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_err = (busy !== 1'b1) ? 1 : 0;
    q = 'x; r = 'x; z = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (busy !== (i <= 8)) busy_err++;
      if (done) begin
        lat = i; q = quotient; r = remainder; z = div_by_zero;
        break;
      end
    end
  endtask

  initial begin
    tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    tbl[3] = '{8'd100, 8'd0,   8'hFF,  8'd100, 1'b1};
    tbl[4] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    tbl[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    tbl[6] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    tbl[7] = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0};
    tbl[8] = '{8'd255, 8'd0,   8'hFF,  8'd255, 1'b1};
    tbl[9] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};

    rst = 1'b1; start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    for (int k = 0; k < 10; k++) begin
      do_div(tbl[k].a, tbl[k].b, gq, gr, gz, glat, gbusy_err);
      chk($sformatf("vec%0d_latency", k), glat, 10);
      chk($sformatf("vec%0d_quotient", k), gq, tbl[k].q);
      chk($sformatf("vec%0d_remainder", k), gr, tbl[k].r);
      chk($sformatf("vec%0d_dbz", k), gz, tbl[k].z);
      chk($sformatf("vec%0d_busy", k), gbusy_err, 0);
    end

    // done is a single-cycle pulse and results hold afterwards
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
    chk("hold_quotient", quotient, 8'hFF);
    chk("hold_dbz", div_by_zero, 1);

    // start re-pulsed at accept+3 must be ignored
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    dividend = 8'd9; divisor = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    glat = -1;
    for (int i = 4; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin glat = i; break; end
    end
    chk("repulse_latency", glat, 10);
    chk("repulse_quotient", quotient, 28);
    chk("repulse_remainder", remainder, 4);

    // back-to-back start in the cycle after done
    do_div(8'd50, 8'd6, gq, gr, gz, glat, gbusy_err);
    chk("b2b_latency", glat, 10);
    chk("b2b_quotient", gq, 8);
    chk("b2b_remainder", gr, 2);

    // reset at accept+5 abandons the division
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    chk("midrst_quotient_held", quotient, 0);
    do_div(8'd200, 8'd7, gq, gr, gz, glat, gbusy_err);
    chk("postrst_latency", glat, 10);
    chk("postrst_quotient", gq, 28);
    chk("postrst_remainder", gr, 4);

    // random sweep against plain arithmetic
    for (int n = 0; n < 1500; n++) begin
      ea = int'($urandom_range(0, 255));
      eb = (n % 16 == 0) ? 0 : int'($urandom_range(0, 255));
      if (eb == 0) begin eq = 255; er = ea; ez = 1; end
      else begin eq = ea / eb; er = ea % eb; ez = 0; end
      do_div(ea[7:0], eb[7:0], gq, gr, gz, glat, gbusy_err);
      chk($sformatf("rnd %0d/%0d latency", ea, eb), glat, 10);
      chk($sformatf("rnd %0d/%0d quotient", ea, eb), gq, eq);
      chk($sformatf("rnd %0d/%0d remainder", ea, eb), gr, er);
      chk($sformatf("rnd %0d/%0d dbz", ea, eb), gz, ez);
      if (eb != 0) begin
        chk($sformatf("rnd %0d/%0d identity", ea, eb), int'(gq) * eb + int'(gr), ea);
        chk($sformatf("rnd %0d/%0d rem_lt_div", ea, eb), (int'(gr) < eb) ? 1 : 0, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
